// File: rtl/ibex_pkg.sv
// ibex_pkg
// Shared types for the execute-stage multiply/divide path.
//   md_op_e        : multdiv operator encoding (MULL/MULH/DIV/REM)
//   md_seq_state_e : state of the multdiv issue/retire sequencer
//   MdImdWidth     : width of the shared intermediate-value register
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_SEQ_IDLE  = 2'b00,
        MD_SEQ_RUN   = 2'b01,
        MD_SEQ_DRAIN = 2'b10,
        MD_SEQ_RESP  = 2'b11
    } md_seq_state_e;

    localparam int unsigned MdImdWidth = 34;

endpackage

// File: rtl/ibex_multdiv_seq.sv
// ibex_multdiv_seq
// Issue/retire sequencer sitting in front of the slow multiplier/divider.
// Accepts one MUL/DIV request over valid/ready, holds its operands for the
// whole operation, drives the multdiv enables, owns the 34-bit intermediate
// value register and buffers the result for writeback. A flush lets the
// in-flight operation drain so the multdiv unit always returns to idle.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake from decode
//   req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i  request fields
//   flush_i                       kill in-flight and same-cycle request
//   md_mult_en_o, md_div_en_o     multdiv enables
//   md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o  latched request
//   md_imd_val_d_i, md_imd_val_we_i, md_imd_val_q_o  intermediate register
//   md_valid_i, md_result_i       multdiv result
//   md_ready_o                    lets multdiv leave its LAST/FINISH state
//   rsp_valid_o, rsp_result_o, rsp_ready_i  response to writeback
//   busy_o                        high whenever not IDLE
module ibex_multdiv_seq
    import ibex_pkg::*;
#(
    parameter int unsigned MaxLatency = 37
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  md_op_e                req_operator_i,
    input  logic [1:0]            req_signed_mode_i,
    input  logic [31:0]           req_op_a_i,
    input  logic [31:0]           req_op_b_i,
    input  logic                  flush_i,

    output logic                  md_mult_en_o,
    output logic                  md_div_en_o,
    output md_op_e                md_operator_o,
    output logic [1:0]            md_signed_mode_o,
    output logic [31:0]           md_op_a_o,
    output logic [31:0]           md_op_b_o,

    input  logic [MdImdWidth-1:0] md_imd_val_d_i,
    input  logic                  md_imd_val_we_i,
    output logic [MdImdWidth-1:0] md_imd_val_q_o,

    input  logic                  md_valid_i,
    input  logic [31:0]           md_result_i,
    output logic                  md_ready_o,

    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_result_o,
    input  logic                  rsp_ready_i,

    output logic                  busy_o
);

    md_seq_state_e         r_state;
    md_seq_state_e         w_stateNext;

    md_op_e                r_operator;
    logic [1:0]            r_signedMode;
    logic [31:0]           r_opA;
    logic [31:0]           r_opB;
    logic [31:0]           r_rspResult;
    logic [MdImdWidth-1:0] r_imdVal;
    logic [5:0]            r_latCnt;

    logic                  w_reqAccept;
    logic                  w_rspLoad;
    logic                  w_imdLoad;
    logic                  w_isMult;
    logic                  w_active;

    assign w_isMult = (r_operator == MD_OP_MULL) || (r_operator == MD_OP_MULH);
    assign w_active = (r_state == MD_SEQ_RUN) || (r_state == MD_SEQ_DRAIN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= MD_SEQ_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // RUN and DRAIN look identical to the multdiv unit (enables and
    // md_ready_o high); they differ only in whether the result is kept.
    // A flush coinciding with md_valid_i has nothing left to drain, so it
    // goes straight to IDLE.
    always_comb begin
        w_stateNext  = r_state;
        req_ready_o  = 1'b0;
        md_mult_en_o = 1'b0;
        md_div_en_o  = 1'b0;
        md_ready_o   = 1'b0;
        rsp_valid_o  = 1'b0;
        w_reqAccept  = 1'b0;
        w_rspLoad    = 1'b0;
        w_imdLoad    = 1'b0;

        unique case (r_state)
            MD_SEQ_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !flush_i) begin
                    w_reqAccept = 1'b1;
                    w_stateNext = MD_SEQ_RUN;
                end
            end

            MD_SEQ_RUN: begin
                md_mult_en_o = w_isMult;
                md_div_en_o  = !w_isMult;
                md_ready_o   = 1'b1;
                w_imdLoad    = md_imd_val_we_i;
                if (md_valid_i) begin
                    if (flush_i) begin
                        w_stateNext = MD_SEQ_IDLE;
                    end else begin
                        w_rspLoad   = 1'b1;
                        w_stateNext = MD_SEQ_RESP;
                    end
                end else if (flush_i) begin
                    w_stateNext = MD_SEQ_DRAIN;
                end
            end

            MD_SEQ_DRAIN: begin
                md_mult_en_o = w_isMult;
                md_div_en_o  = !w_isMult;
                md_ready_o   = 1'b1;
                w_imdLoad    = md_imd_val_we_i;
                if (md_valid_i) begin
                    w_stateNext = MD_SEQ_IDLE;
                end
            end

            MD_SEQ_RESP: begin
                rsp_valid_o = 1'b1;
                req_ready_o = rsp_ready_i && !flush_i;
                if (flush_i) begin
                    w_stateNext = MD_SEQ_IDLE;
                end else if (rsp_ready_i) begin
                    if (req_valid_i) begin
                        w_reqAccept = 1'b1;
                        w_stateNext = MD_SEQ_RUN;
                    end else begin
                        w_stateNext = MD_SEQ_IDLE;
                    end
                end
            end

            default: begin
                w_stateNext = MD_SEQ_IDLE;
            end
        endcase
    end

    // Operand latch: only an accepted request may change what the multdiv
    // unit sees, so the operands are frozen across RUN and DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_operator   <= MD_OP_MULL;
            r_signedMode <= 2'b00;
            r_opA        <= 32'd0;
            r_opB        <= 32'd0;
        end else if (w_reqAccept) begin
            r_operator   <= req_operator_i;
            r_signedMode <= req_signed_mode_i;
            r_opA        <= req_op_a_i;
            r_opB        <= req_op_b_i;
        end
    end

    // One-entry response buffer; holds its value until overwritten by the
    // next kept result so rsp_result_o is stable while writeback stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rspResult <= 32'd0;
        end else if (w_rspLoad) begin
            r_rspResult <= md_result_i;
        end
    end

    // Shared intermediate-value register, written only while the multdiv
    // unit is actually operating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imdVal <= '0;
        end else if (w_imdLoad) begin
            r_imdVal <= md_imd_val_d_i;
        end
    end

    // Cycles already spent in RUN/DRAIN for the current operation; only
    // feeds the latency check below.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_latCnt <= 6'd0;
        end else if (!w_active) begin
            r_latCnt <= 6'd0;
        end else if (r_latCnt != 6'h3F) begin
            r_latCnt <= r_latCnt + 6'd1;
        end
    end

    assign md_operator_o    = r_operator;
    assign md_signed_mode_o = r_signedMode;
    assign md_op_a_o        = r_opA;
    assign md_op_b_o        = r_opB;
    assign md_imd_val_q_o   = r_imdVal;
    assign rsp_result_o     = r_rspResult;
    assign busy_o           = (r_state != MD_SEQ_IDLE);

    aLatencyBound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_active |-> (32'(r_latCnt) < MaxLatency));

    aValidOnlyActive : assert property (@(posedge clk_i) disable iff (!rst_ni)
        md_valid_i |-> w_active);

    aReqStable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=>
            ($stable(req_operator_i) && $stable(req_signed_mode_i) &&
             $stable(req_op_a_i) && $stable(req_op_b_i)));

endmodule

// File: tb/tb_ibex_multdiv_seq.sv
// tb_ibex_multdiv_seq
// Self-checking bench for ibex_multdiv_seq. A behavioural multdiv stand-in
// answers the sequencer's enables after a fixed latency; expected results
// come from a constant vector table and are queued on request acceptance,
// then popped when writeback accepts a response.
module tb_ibex_multdiv_seq;
    import ibex_pkg::*;

    localparam int MulLat = 3;
    localparam int DivLat = 10;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    md_op_e      req_operator_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic        flush_i;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    md_op_e      md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic [33:0] md_imd_val_d_i;
    logic        md_imd_val_we_i;
    logic [33:0] md_imd_val_q_o;
    logic        md_valid_i;
    logic [31:0] md_result_i;
    logic        md_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_result_o;
    logic        rsp_ready_i;
    logic        busy_o;

    ibex_multdiv_seq #(.MaxLatency(37)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_operator_i    (req_operator_i),
        .req_signed_mode_i (req_signed_mode_i),
        .req_op_a_i        (req_op_a_i),
        .req_op_b_i        (req_op_b_i),
        .flush_i           (flush_i),
        .md_mult_en_o      (md_mult_en_o),
        .md_div_en_o       (md_div_en_o),
        .md_operator_o     (md_operator_o),
        .md_signed_mode_o  (md_signed_mode_o),
        .md_op_a_o         (md_op_a_o),
        .md_op_b_o         (md_op_b_o),
        .md_imd_val_d_i    (md_imd_val_d_i),
        .md_imd_val_we_i   (md_imd_val_we_i),
        .md_imd_val_q_o    (md_imd_val_q_o),
        .md_valid_i        (md_valid_i),
        .md_result_i       (md_result_i),
        .md_ready_o        (md_ready_o),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_result_o      (rsp_result_o),
        .rsp_ready_i       (rsp_ready_i),
        .busy_o            (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        md_op_e      op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] sbQ[$];
    int          nChecks = 0;
    int          nPass   = 0;
    int          imdCnt  = 0;
    int          mdCnt   = 0;
    logic [33:0] lastEnImd = '0;

    task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNote(input string name);
        nChecks++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Behavioural multdiv unit: computes from the sequencer's latched fields.
    function automatic logic [31:0] mdModel(input md_op_e op, input logic [1:0] mode,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea;
        logic [63:0]        eb;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        ea = mode[0] ? {{32{a[31]}}, a} : {32'd0, a};
        eb = mode[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        sa = a;
        sb = b;
        r  = 32'd0;
        case (op)
            MD_OP_MULL: r = p[31:0];
            MD_OP_MULH: r = p[63:32];
            default: begin
                if (b == 32'd0) begin
                    r = (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
                end else if (mode == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        r = (op == MD_OP_DIV) ? a : 32'd0;
                    end else begin
                        r = (op == MD_OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
                    end
                end else begin
                    r = (op == MD_OP_DIV) ? (a / b) : (a % b);
                end
            end
        endcase
        return r;
    endfunction

    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            md_valid_i = 1'b0;
            mdCnt      = 0;
        end else begin
            imdCnt++;
            md_imd_val_d_i = {2'b10, 32'(imdCnt)};
            if (md_valid_i) begin
                md_valid_i = 1'b0;
                mdCnt      = 0;
            end else if (md_mult_en_o || md_div_en_o) begin
                lastEnImd = md_imd_val_d_i;
                mdCnt++;
                if (mdCnt == (md_mult_en_o ? MulLat : DivLat)) begin
                    md_valid_i  = 1'b1;
                    md_result_i = mdModel(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
                end
            end else begin
                mdCnt = 0;
            end
        end
    end

    // Response monitor: a handshake at the coming edge pops the scoreboard.
    always @(negedge clk_i) begin
        #2;
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL rsp_unexpected: got %h expected no response", rsp_result_o);
            end else begin
                checkOutput("rsp_result", 34'(rsp_result_o), 34'(sbQ.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input md_op_e op, input logic [1:0] mode, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input bit doPush);
        int t = 0;
        @(negedge clk_i);
        req_operator_i    = op;
        req_signed_mode_i = mode;
        req_op_a_i        = a;
        req_op_b_i        = b;
        req_valid_i       = 1'b1;
        #1;
        while (!req_ready_o && t < 200) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        if (t >= 200) failNote("req_accept_timeout");
        if (doPush) sbQ.push_back(exp);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic waitDone();
        int t = 0;
        while ((sbQ.size() != 0 || busy_o) && t < 300) begin
            @(negedge clk_i);
            #3;
            t++;
        end
        if (t >= 300) failNote("done_timeout");
    endtask

    task automatic waitRspValid();
        int t = 0;
        while (!rsp_valid_o && t < 100) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        if (t >= 100) failNote("rsp_valid_timeout");
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},      34'(busy_o),         34'd0);
        checkOutput({tag, "_req_ready"}, 34'(req_ready_o),    34'd1);
        checkOutput({tag, "_mult_en"},   34'(md_mult_en_o),   34'd0);
        checkOutput({tag, "_div_en"},    34'(md_div_en_o),    34'd0);
        checkOutput({tag, "_md_ready"},  34'(md_ready_o),     34'd0);
        checkOutput({tag, "_rsp_valid"}, 34'(rsp_valid_o),    34'd0);
        checkOutput({tag, "_rsp_res"},   34'(rsp_result_o),   34'd0);
        checkOutput({tag, "_imd_q"},     md_imd_val_q_o,      34'd0);
        checkOutput({tag, "_op_a"},      34'(md_op_a_o),      34'd0);
        checkOutput({tag, "_op_b"},      34'(md_op_b_o),      34'd0);
        checkOutput({tag, "_mode"},      34'(md_signed_mode_o), 34'd0);
    endtask

    initial begin
        logic [33:0] imdSaved;
        bit          sawValid;
        bit          sawRsp;
        int          busyCycles;

        vecs[0]  = '{"mull_7x6",       MD_OP_MULL, 2'b11, 32'd7,         32'd6,         32'h0000_002A};
        vecs[1]  = '{"mulh_ss_min",    MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{"div_s_m7_2",     MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[3]  = '{"rem_s_m7_2",     MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{"div_by0",        MD_OP_DIV,  2'b11, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF};
        vecs[5]  = '{"rem_by0",        MD_OP_REM,  2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234};
        vecs[6]  = '{"div_u_100_7",    MD_OP_DIV,  2'b00, 32'd100,       32'd7,         32'h0000_000E};
        vecs[7]  = '{"mulh_uu_max",    MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[8]  = '{"mulh_su",        MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[9]  = '{"div_u_max_2",    MD_OP_DIV,  2'b00, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF};
        vecs[10] = '{"div_s_ovf",      MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"rem_u_100_7",    MD_OP_REM,  2'b00, 32'd100,       32'd7,         32'h0000_0002};

        rst_ni            = 1'b0;
        req_valid_i       = 1'b0;
        req_operator_i    = MD_OP_MULL;
        req_signed_mode_i = 2'b00;
        req_op_a_i        = 32'd0;
        req_op_b_i        = 32'd0;
        flush_i           = 1'b0;
        md_imd_val_d_i    = '0;
        md_imd_val_we_i   = 1'b1;
        md_valid_i        = 1'b0;
        md_result_i       = 32'd0;
        rsp_ready_i       = 1'b1;

        #1;
        checkResetOutputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            waitDone();
        end

        $display("[TB] flush with same-cycle request in IDLE");
        @(negedge clk_i);
        req_operator_i = MD_OP_MULL;
        req_op_a_i     = 32'd5;
        req_op_b_i     = 32'd5;
        req_valid_i    = 1'b1;
        flush_i        = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        #1;
        checkOutput("idle_flush_busy", 34'(busy_o), 34'd0);

        $display("[TB] flush 5 cycles into a DIV");
        applyStimulus(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (4) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i    = 1'b0;
        sawValid   = 1'b0;
        sawRsp     = 1'b0;
        busyCycles = 0;
        for (int t = 0; t < 50; t++) begin
            #3;
            if (!busy_o) break;
            busyCycles++;
            if (md_valid_i) sawValid = 1'b1;
            if (rsp_valid_o) sawRsp = 1'b1;
            @(negedge clk_i);
        end
        checkOutput("drain_busy_until_valid", 34'(sawValid), 34'd1);
        checkOutput("drain_busy_cycles", 34'(busyCycles > 2), 34'd1);
        checkOutput("drain_no_rsp", 34'(sawRsp), 34'd0);
        checkOutput("drain_idle", 34'(busy_o), 34'd0);
        applyStimulus(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 32'h0000_000E, 1'b1);
        waitDone();

        $display("[TB] writeback backpressure and back-to-back request");
        rsp_ready_i = 1'b0;
        applyStimulus(MD_OP_MULL, 2'b11, 32'd11, 32'd13, 32'h0000_008F, 1'b1);
        waitRspValid();
        imdSaved          = lastEnImd;
        req_operator_i    = MD_OP_REM;
        req_signed_mode_i = 2'b00;
        req_op_a_i        = 32'd100;
        req_op_b_i        = 32'd7;
        req_valid_i       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("hold_rsp_result", 34'(rsp_result_o), 34'h8F);
            checkOutput("hold_rsp_valid",  34'(rsp_valid_o),  34'd1);
            checkOutput("hold_req_ready",  34'(req_ready_o),  34'd0);
            checkOutput("hold_imd_q",      md_imd_val_q_o,    imdSaved);
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("b2b_req_ready", 34'(req_ready_o), 34'd1);
        sbQ.push_back(32'h0000_0002);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        checkOutput("b2b_run_div_en", 34'(md_div_en_o), 34'd1);
        checkOutput("b2b_run_rsp_valid", 34'(rsp_valid_o), 34'd0);
        waitDone();

        $display("[TB] flush while holding a response");
        rsp_ready_i = 1'b0;
        applyStimulus(MD_OP_MULL, 2'b00, 32'd2, 32'd2, 32'd4, 1'b1);
        waitRspValid();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        checkOutput("resp_flush_rsp_valid", 34'(rsp_valid_o), 34'd0);
        checkOutput("resp_flush_busy", 34'(busy_o), 34'd0);
        if (sbQ.size() != 0) void'(sbQ.pop_front());
        rsp_ready_i = 1'b1;

        $display("[TB] reset mid-RUN");
        applyStimulus(MD_OP_DIV, 2'b11, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("pre_reset_busy", 34'(busy_o), 34'd1);
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("midrst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(MD_OP_MULL, 2'b11, 32'd3, 32'd3, 32'd9, 1'b1);
        waitDone();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ibex_multdiv_seq.md
# ibex_multdiv_seq

Issue/retire sequencer directly upstream of the slow multiplier/divider in the execute path. It accepts one MUL/DIV request from decode over a valid/ready handshake and holds the operands stable for the whole operation. It drives the multdiv enables, owns the shared 34-bit intermediate-value register, and captures the result into a one-entry response buffer for writeback. A flush never aborts the multdiv unit mid-operation: the operation drains and its result is discarded, so the unit always returns to its idle state.

## Interface
- MaxLatency, 37: maximum cycles from entering RUN to md_valid_i; simulation assertion bound only.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid from decode
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_operator_i  in  md_op_e  MULL/MULH/DIV/REM
- req_signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed
- req_op_a_i, req_op_b_i  in  32 each  operands
- flush_i  in  1  kill the in-flight and same-cycle request
- md_mult_en_o, md_div_en_o  out  1 each  multdiv enables
- md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o  out  latched copies of the request fields
- md_imd_val_d_i  in  34  intermediate-value next value
- md_imd_val_we_i  in  1  intermediate-value write enable
- md_imd_val_q_o  out  34  intermediate-value register
- md_valid_i  in  1  multdiv result valid
- md_result_i  in  32  multdiv result
- md_ready_o  out  1  lets multdiv leave its LAST/FINISH state
- rsp_valid_o  out  1  result valid to writeback
- rsp_result_o  out  32  result
- rsp_ready_i  in  1  writeback accepts
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, RESP. The state enum lives in ibex_pkg.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & !flush_i: latch operator, mode and operands, then go to RUN.
- RUN:
  - md_mult_en_o = op is MULL/MULH; md_div_en_o = op is DIV/REM.
  - md_ready_o = 1.
  - On md_valid_i: load md_result_i into the response buffer and go to RESP.
  - On flush_i without md_valid_i: go to DRAIN.
  - If md_valid_i and flush_i occur in the same cycle, the result is discarded and the next state is IDLE.
- DRAIN:
  - Enables stay asserted and md_ready_o = 1.
  - On md_valid_i: discard the result and go to IDLE.
  - flush_i is ignored in this state.
- RESP:
  - rsp_valid_o = 1; rsp_result_o is stable until accepted.
  - req_ready_o = rsp_ready_i & !flush_i.
  - On rsp_ready_i: a new request in the same cycle goes to RUN, otherwise go to IDLE.
  - On flush_i: clear rsp_valid_o and go to IDLE.
- Enables are low in IDLE and RESP, so the multdiv unit sits in its idle state.
- Intermediate-value register:
  - Loads md_imd_val_d_i when md_imd_val_we_i is high and the state is RUN or DRAIN.
  - Holds its value otherwise.
- Operand latch updates only on an accepted request. The md_* outputs remain stable through RUN and DRAIN.

## Timing
- Reset values:
  - State IDLE.
  - All enables, rsp_valid_o and busy_o are 0; req_ready_o is 1.
  - md_ready_o is 0.
  - Intermediate-value register, operand latch and rsp_result_o are all zero.
- Request accepted in cycle T; enables are high from T+1.
- md_valid_i at cycle U gives rsp_valid_o at U+1, so there is one cycle of capture latency.
- Back-to-back requests: a response handshake and a new request in the same cycle put RUN in the next cycle, with no idle bubble.
- Reset mid-operation: all state clears asynchronously. The parent resets the multdiv unit on the same reset.
- Assertions:
  - RUN or DRAIN lasts at most MaxLatency cycles.
  - md_valid_i is never high outside RUN or DRAIN.
  - Request fields are stable while req_valid_i & !req_ready_o.

## Structure
- ibex_pkg gets the md_seq_state_e typedef. md_op_e is reused.
- No sub-module: a single FSM plus registers, about 150-250 lines of RTL.
- The multdiv unit is instantiated beside this block in the parent, not inside it.

## Test plan
- Signed MULL, 7 × 6: rsp_result_o = 0x0000002A.
- MULH signed/signed, 0x80000000 × 0x80000000: result 0x40000000.
- DIV signed, −7 / 2: 0xFFFFFFFD.
- REM signed, −7 % 2: 0xFFFFFFFF.
- DIV by 0, 0x1234 / 0: result 0xFFFFFFFF.
- REM by 0, 0x1234 % 0: result 0x00001234.
- Flush 5 cycles into a DIV:
  - busy_o stays high until md_valid_i, and no rsp_valid_o is produced.
  - The next request, 100 / 7 unsigned, returns 0x0000000E.
- Hold rsp_ready_i low for 5 cycles: rsp_result_o stays stable and req_ready_o stays low. Raise rsp_ready_i together with a new request: RUN follows in the next cycle.
- Assert rst_ni mid-RUN: all outputs return to their reset values immediately, and a post-reset MULL 3 × 3 returns 9.
